// File: rtl/pc_branch_unit_if.sv
// Branch-request / PC-result bundle between decode+CPSR stages and pc_branch_unit.
interface pc_branch_unit_if #(
   parameter int ADDR_W   = 32,
   parameter int OFFSET_W = 24
);
   logic                stall;
   logic                br_valid;
   logic [1:0]          br_type;
   logic [OFFSET_W-1:0] br_offset;
   logic [ADDR_W-1:0]   br_reg_target;
   logic                cpsr_flag;
   logic [ADDR_W-1:0]   pc;
   logic [ADDR_W-1:0]   pc_plus4;
   logic                branch_taken;
   logic                link_we;
   logic [ADDR_W-1:0]   link_data;
   logic                ras_empty;
   logic                ras_full;
   logic                ras_miss;
   logic [31:0]         taken_cnt;
   logic [31:0]         nottaken_cnt;

   modport master (
      output stall, br_valid, br_type, br_offset, br_reg_target, cpsr_flag,
      input  pc, pc_plus4, branch_taken, link_we, link_data,
             ras_empty, ras_full, ras_miss, taken_cnt, nottaken_cnt
   );

   modport slave (
      input  stall, br_valid, br_type, br_offset, br_reg_target, cpsr_flag,
      output pc, pc_plus4, branch_taken, link_we, link_data,
             ras_empty, ras_full, ras_miss, taken_cnt, nottaken_cnt
   );
endinterface

// File: rtl/pc_branch_unit.sv
// PC select + branch resolution with a circular return-address stack.
// Define BRANCH_STATS_EN to build the saturating taken/not-taken counters.
module pc_branch_unit #(
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0,
   parameter int                RAS_DEPTH = 4,
   parameter int                OFFSET_W  = 24
)(
   input  logic             clk,
   input  logic             reset,
   pc_branch_unit_if.slave  bus
);
   localparam int PW = $clog2(RAS_DEPTH);
   localparam int CW = $clog2(RAS_DEPTH + 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(RAS_DEPTH);
   localparam logic [PW-1:0] PTR_LAST = PW'(RAS_DEPTH - 1);
   localparam logic [1:0] BR_B = 2'b00, BR_BL = 2'b01, BR_RET = 2'b10, BR_BX = 2'b11;

   logic [RAS_DEPTH-1:0][ADDR_W-1:0] ras;
   logic [PW-1:0]     wp, wp_inc, wp_dec;
   logic [CW-1:0]     cnt;
   logic [ADDR_W-1:0] pc, pc_plus4, next_pc, rel_tgt, reg_tgt;
   logic              taken, empty, full, push, pop, miss_q;

   assign pc_plus4 = pc + ADDR_W'(4);
   assign rel_tgt  = pc_plus4 +
                     ({{(ADDR_W-OFFSET_W){bus.br_offset[OFFSET_W-1]}}, bus.br_offset} << 2);
   assign reg_tgt  = bus.br_reg_target & ~ADDR_W'(3);
   assign taken    = bus.br_valid & bus.cpsr_flag & ~bus.stall;
   assign empty    = (cnt == '0);
   assign full     = (cnt == CNT_FULL);
   assign push     = taken & (bus.br_type == BR_BL);
   assign pop      = taken & (bus.br_type == BR_RET) & ~empty;
   // pointer arithmetic wraps explicitly so non-power-of-2 depths work
   assign wp_inc   = (wp == PTR_LAST) ? '0 : wp + PW'(1);
   assign wp_dec   = (wp == '0) ? PTR_LAST : wp - PW'(1);

   always_comb begin
      next_pc = pc_plus4;
      if (taken) begin
         case (bus.br_type)
            BR_B, BR_BL: next_pc = rel_tgt;
            BR_RET:      next_pc = empty ? reg_tgt : ras[wp_dec];
            BR_BX:       next_pc = reg_tgt;
            default:     next_pc = pc_plus4;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc     <= RESET_PC;
         wp     <= '0;
         cnt    <= '0;
         miss_q <= 1'b0;
      end else if (!bus.stall) begin
         pc     <= next_pc;
         miss_q <= taken & (bus.br_type == BR_RET) & empty;
         if (push) begin
            wp <= wp_inc;
            if (!full) cnt <= cnt + CW'(1);
         end else if (pop) begin
            wp  <= wp_dec;
            cnt <= cnt - CW'(1);
         end
      end
   end

   // entries need no reset: count gates every read
   always_ff @(posedge clk) begin
      if (!reset && push) ras[wp] <= pc_plus4;
   end

`ifdef BRANCH_STATS_EN
   logic [31:0] tk_cnt, nt_cnt;
   always_ff @(posedge clk) begin
      if (reset) begin
         tk_cnt <= '0;
         nt_cnt <= '0;
      end else if (!bus.stall && bus.br_valid) begin
         if (bus.cpsr_flag) begin
            if (tk_cnt != '1) tk_cnt <= tk_cnt + 32'd1;
         end else if (nt_cnt != '1) begin
            nt_cnt <= nt_cnt + 32'd1;
         end
      end
   end
   assign bus.taken_cnt    = tk_cnt;
   assign bus.nottaken_cnt = nt_cnt;
`else
   assign bus.taken_cnt    = '0;
   assign bus.nottaken_cnt = '0;
`endif

   assign bus.pc           = pc;
   assign bus.pc_plus4     = pc_plus4;
   assign bus.branch_taken = taken;
   assign bus.link_we      = push;
   assign bus.link_data    = pc_plus4;
   assign bus.ras_empty    = empty;
   assign bus.ras_full     = full;
   assign bus.ras_miss     = miss_q;
endmodule
